// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns a pipeline load/store into a single ready/valid
// bus transaction, stalling IF..MEM until the response returns.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        req_valid,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;
    logic [31:0] read_data_reg;
    logic        misalign_reg;

    logic        access;
    logic        bad_access;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted_rdata;
    logic [31:0] load_fmt;

    assign access = MemWriteM | (ResultSrcM == 2'b01);

    always_comb begin
        bad_access = 1'b0;
        case (Funct3M)
            3'b001, 3'b101:         bad_access = ALUResultM[0];
            3'b010:                 bad_access = |ALUResultM[1:0];
            3'b011, 3'b110, 3'b111: bad_access = 1'b1;
            default:                bad_access = 1'b0;
        endcase
    end

    always_comb begin
        case (Funct3M[1:0])
            2'b00:   be_next = 4'b0001 << ALUResultM[1:0];
            2'b01:   be_next = 4'b0011 << ALUResultM[1:0];
            default: be_next = 4'b1111;
        endcase
    end

    // Store data is replicated into every lane so the byte enables alone pick the target.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_next[8*gi +: 8] =
                (Funct3M[1:0] == 2'b00) ? WriteDataM[7:0] :
                (Funct3M[1:0] == 2'b01) ? WriteDataM[8*(gi%2) +: 8] :
                                          WriteDataM[8*gi +: 8];
        end
    endgenerate

    assign shifted_rdata = rsp_rdata >> {off_reg, 3'b000};

    always_comb begin
        case (funct3_reg)
            3'b000:  load_fmt = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            3'b100:  load_fmt = {24'h0, shifted_rdata[7:0]};
            3'b001:  load_fmt = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b101:  load_fmt = {16'h0, shifted_rdata[15:0]};
            default: load_fmt = rsp_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            be_reg        <= 4'h0;
            funct3_reg    <= 3'h0;
            off_reg       <= 2'h0;
            read_data_reg <= 32'h0;
            misalign_reg  <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (access && bad_access) begin
                        misalign_reg <= 1'b1;
                    end else if (access) begin
                        we_reg     <= MemWriteM;
                        addr_reg   <= {ALUResultM[31:2], 2'b00};
                        wdata_reg  <= wdata_next;
                        be_reg     <= be_next;
                        funct3_reg <= Funct3M;
                        off_reg    <= ALUResultM[1:0];
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready) state_reg <= WAIT;
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (!we_reg) read_data_reg <= load_fmt;
                        state_reg <= DONE;
                    end
                end
                // The pipeline still shows the finished instruction here; do not restart it.
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_reg)
            IDLE:    StallM = access & ~bad_access;
            REQ:     StallM = 1'b1;
            WAIT:    StallM = 1'b1;
            default: StallM = 1'b0;
        endcase
    end

    assign req_valid = (state_reg == REQ);
    assign req_we    = we_reg;
    assign req_addr  = addr_reg;
    assign req_wdata = wdata_reg;
    assign req_be    = be_reg;
    assign ReadDataM = read_data_reg;
    assign MisalignM = misalign_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random loads/stores checked
// against an arithmetic model of sizes, lanes and extension.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_bad(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        return (addr % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = size_of(f3);
        int v = ((1 << n) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int n = size_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] v = word >> (8 * (addr % 4));
        case (f3)
            3'b000:  return 32'(signed'(v[7:0]));
            3'b100:  return 32'(v[7:0]);
            3'b001:  return 32'(signed'(v[15:0]));
            3'b101:  return 32'(v[15:0]);
            default: return word;
        endcase
    endfunction

    // One full pipeline access: drives the request, honours the ready/response
    // delays and checks every visible output along the way.
    task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int rdy_dly, input int rsp_dly);
        bit          bad   = is_bad(f3, addr);
        logic [31:0] e_adr = addr & 32'hFFFF_FFFC;
        logic [3:0]  e_be  = model_be(f3, addr);
        logic [31:0] e_wd  = model_wdata(f3, wdata);
        @(negedge clk);
        MemWriteM = we; ResultSrcM = we ? 2'b00 : 2'b01; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wdata; req_ready = 1'b0; rsp_valid = 1'b0;
        #1; checks++;
        if (StallM !== !bad) begin
            errors++; $display("FAIL idle_stall addr=%h f3=%0d got=%b want=%b", addr, f3, StallM, !bad);
        end
        if (bad) begin
            @(negedge clk); MemWriteM = 1'b0; ResultSrcM = 2'b00;
            #1; checks++;
            if ({MisalignM, req_valid, StallM, ReadDataM} !== {3'b100, exp_rd}) begin
                errors++; $display("FAIL misalign_pulse addr=%h f3=%0d got=%b%b%b rd=%h want=100 rd=%h",
                                   addr, f3, MisalignM, req_valid, StallM, ReadDataM, exp_rd);
            end
            @(negedge clk); #1; checks++;
            if (MisalignM !== 1'b0) begin
                errors++; $display("FAIL misalign_one_cycle got=%b want=0", MisalignM);
            end
            $display("txn misaligned f3=%0d addr=%h", f3, addr);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            // response strobes while in REQ must have no effect
            rsp_valid = (i < rdy_dly); rsp_rdata = $urandom; req_ready = (i == rdy_dly);
            #1; checks++;
            if ({req_valid, StallM, req_we, req_addr, req_be, req_wdata} !== {2'b11, we, e_adr, e_be, e_wd}) begin
                errors++; $display("FAIL req_fields cyc=%0d got v=%b s=%b we=%b a=%h be=%b wd=%h want we=%b a=%h be=%b wd=%h",
                                   i, req_valid, StallM, req_we, req_addr, req_be, req_wdata, we, e_adr, e_be, e_wd);
            end
        end
        for (int j = 0; j <= rsp_dly; j++) begin
            @(negedge clk);
            req_ready = 1'b0; rsp_valid = 1'b0;
            #1; checks++;
            if ({req_valid, StallM} !== 2'b01) begin
                errors++; $display("FAIL wait_state cyc=%0d got v=%b s=%b want v=0 s=1", j, req_valid, StallM);
            end
            if (j == rsp_dly) begin rsp_valid = 1'b1; rsp_rdata = rdata; end
        end
        if (!we) exp_rd = model_load(f3, addr, rdata);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1; checks++;
        if ({req_valid, StallM, ReadDataM} !== {2'b00, exp_rd}) begin
            errors++; $display("FAIL done_state got v=%b s=%b rd=%h want v=0 s=0 rd=%h",
                               req_valid, StallM, ReadDataM, exp_rd);
        end
        @(negedge clk);
        MemWriteM = 1'b0; ResultSrcM = 2'b00;
        #1; checks++;
        if ({req_valid, StallM, ReadDataM} !== {2'b00, exp_rd}) begin
            errors++; $display("FAIL back_to_idle got v=%b s=%b rd=%h want rd=%h",
                               req_valid, StallM, ReadDataM, exp_rd);
        end
        $display("txn %s f3=%0d addr=%h wdata=%h rdata=%h rd=%h", we ? "store" : "load",
                 f3, addr, wdata, rdata, ReadDataM);
    endtask

    task automatic test_reset();
        reset = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010;
        ALUResultM = 32'h40; WriteDataM = 32'h0; req_ready = 1'b1; rsp_valid = 1'b1;
        rsp_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        ResultSrcM = 2'b00; req_ready = 1'b0; rsp_valid = 1'b0;
        #1; checks++;
        if ({ReadDataM, StallM, MisalignM, req_valid, req_addr, req_be} !== {32'h0, 3'b000, 32'h0, 4'h0}) begin
            errors++; $display("FAIL reset_state rd=%h s=%b m=%b v=%b a=%h be=%b",
                               ReadDataM, StallM, MisalignM, req_valid, req_addr, req_be);
        end
        exp_rd = 32'h0;
        reset = 1'b0;
        $display("txn reset");
    endtask

    task automatic test_directed_loads();
        run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0);
        run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0);
        run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h9876F00D, 1, 2);
    endtask

    task automatic test_store();
        run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0);
        run_access(1'b1, 3'b000, 32'h205, 32'hAAAA_5A11, 32'h0, 0, 1);
    endtask

    task automatic test_misalign();
        run_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
        run_access(1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0);
        run_access(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_stall_and_reset();
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFE_0001, 5, 0);
        @(negedge clk);
        MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h300;
        @(negedge clk); req_ready = 1'b1;
        @(negedge clk); req_ready = 1'b0;
        #1; checks++;
        if ({req_valid, StallM} !== 2'b01) begin
            errors++; $display("FAIL pre_reset_wait got v=%b s=%b want v=0 s=1", req_valid, StallM);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; ResultSrcM = 2'b00; rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678;
        exp_rd = 32'h0;
        #1; checks++;
        if ({req_valid, StallM, ReadDataM} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL reset_abort got v=%b s=%b rd=%h want rd=0", req_valid, StallM, ReadDataM);
        end
        @(negedge clk);
        rsp_valid = 1'b0;
        #1; checks++;
        if ({req_valid, StallM, ReadDataM} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL late_rsp_ignored got v=%b s=%b rd=%h want rd=0", req_valid, StallM, ReadDataM);
        end
        $display("txn reset_in_wait");
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                       $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed_loads();
        test_store();
        test_misalign();
        test_stall_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
